sif_wa_bridge: RTL and testbench

- Slave on the SIF X-side access bus (xa_*). Single-cycle write and read strobes, 16-bit address and data.
- Holds a small local register file and a status register.
- Forwards writes in the W-region to the W-side write port (wa_*) through a FIFO, with backpressure via wa_rdy.
- Sits directly downstream of the X-side driver; its wa_* outputs feed the W-side consumer and monitor.

---
 rtl/sif_wa_bridge.sv | 147 ++++++++++++++
 tb/tb_sif_wa_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sif_wa_bridge.sv
// rtl/sif_wa_bridge.sv - X-side access slave with local regs, status and W-side write forwarding FIFO
module sif_wa_bridge #(
    parameter int          NUM_REGS   = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] WA_BASE    = 16'h1000,
    parameter logic [15:0] STAT_ADDR  = 16'h00FE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        xa_wr_s,
    input  logic        xa_rd_s,
    input  logic [15:0] xa_addr,
    input  logic [15:0] xa_data_wr,
    output logic [15:0] xa_data_rd,
    input  logic        wa_rdy,
    output logic        wa_wr_s,
    output logic [15:0] wa_addr,
    output logic [15:0] wa_data_wr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [15:0]   regs_q [NUM_REGS];
    logic [15:0]   regs_d [NUM_REGS];
    logic [31:0]   mem_q  [FIFO_DEPTH];
    logic [31:0]   mem_d  [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          perr_q, perr_d;
    logic [15:0]   xa_data_rd_q, xa_data_rd_d;
    logic          wa_wr_s_q, wa_wr_s_d;
    logic [15:0]   wa_addr_q, wa_addr_d;
    logic [15:0]   wa_data_wr_q, wa_data_wr_d;

    logic hit_local, hit_stat, hit_fwd;
    logic do_wr, do_rd, pop, push, full;

    // Decode the access, run the FIFO (pop first so a full FIFO can still accept), update flags and read data
    always_comb begin
        regs_d       = regs_q;
        mem_d        = mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        perr_d       = perr_q;
        xa_data_rd_d = xa_data_rd_q;
        wa_wr_s_d    = 1'b0;
        wa_addr_d    = wa_addr_q;
        wa_data_wr_d = wa_data_wr_q;
        push         = 1'b0;

        hit_local = xa_addr < 16'(NUM_REGS);
        hit_stat  = xa_addr == STAT_ADDR;
        hit_fwd   = xa_addr >= WA_BASE;
        do_wr     = xa_wr_s && !xa_rd_s;
        do_rd     = xa_rd_s && !xa_wr_s;
        pop       = wa_rdy && (count_q != '0);
        full      = count_q == CW'(FIFO_DEPTH);

        if (pop) begin
            {wa_addr_d, wa_data_wr_d} = mem_q[rptr_q];
            wa_wr_s_d                 = 1'b1;
            rptr_d                    = rptr_q + AW'(1);
        end

        if (xa_wr_s && xa_rd_s) begin
            perr_d = 1'b1;
        end

        if (do_wr) begin
            if (hit_local) begin
                regs_d[xa_addr[RW-1:0]] = xa_data_wr;
            end else if (hit_stat) begin
                if (xa_data_wr[15]) ovf_d  = 1'b0;
                if (xa_data_wr[14]) perr_d = 1'b0;
            end else if (hit_fwd) begin
                if (full && !pop) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
        end

        if (push) begin
            mem_d[wptr_q] = {xa_addr, xa_data_wr};
            wptr_d        = wptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Status shows pre-edge flag and count values
        if (do_rd) begin
            if (hit_local) begin
                xa_data_rd_d = regs_q[xa_addr[RW-1:0]];
            end else if (hit_stat) begin
                xa_data_rd_d = {ovf_q, perr_q, 6'b0, 8'(count_q)};
            end else begin
                xa_data_rd_d = 16'h0000;
            end
        end
    end

    // State registers; reset empties the FIFO and clears any in-flight output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            perr_q       <= 1'b0;
            xa_data_rd_q <= '0;
            wa_wr_s_q    <= 1'b0;
            wa_addr_q    <= '0;
            wa_data_wr_q <= '0;
        end else begin
            regs_q       <= regs_d;
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            perr_q       <= perr_d;
            xa_data_rd_q <= xa_data_rd_d;
            wa_wr_s_q    <= wa_wr_s_d;
            wa_addr_q    <= wa_addr_d;
            wa_data_wr_q <= wa_data_wr_d;
        end
    end

    assign xa_data_rd = xa_data_rd_q;
    assign wa_wr_s    = wa_wr_s_q;
    assign wa_addr    = wa_addr_q;
    assign wa_data_wr = wa_data_wr_q;

endmodule

// File: tb/tb_sif_wa_bridge.sv
// tb/tb_sif_wa_bridge.sv - self-checking bench for sif_wa_bridge with a queue-based reference model
module tb_sif_wa_bridge;

    localparam int          NUM_REGS   = 16;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [15:0] WA_BASE    = 16'h1000;
    localparam logic [15:0] STAT_ADDR  = 16'h00FE;

    logic        clk;
    logic        rst_n;
    logic        xa_wr_s;
    logic        xa_rd_s;
    logic [15:0] xa_addr;
    logic [15:0] xa_data_wr;
    logic [15:0] xa_data_rd;
    logic        wa_rdy;
    logic        wa_wr_s;
    logic [15:0] wa_addr;
    logic [15:0] wa_data_wr;

    sif_wa_bridge #(
        .NUM_REGS  (NUM_REGS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .WA_BASE   (WA_BASE),
        .STAT_ADDR (STAT_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .xa_wr_s   (xa_wr_s),
        .xa_rd_s   (xa_rd_s),
        .xa_addr   (xa_addr),
        .xa_data_wr(xa_data_wr),
        .xa_data_rd(xa_data_rd),
        .wa_rdy    (wa_rdy),
        .wa_wr_s   (wa_wr_s),
        .wa_addr   (wa_addr),
        .wa_data_wr(wa_data_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain register array, a queue for the FIFO, two sticky flags
    logic [15:0] m_regs [NUM_REGS];
    logic [31:0] m_q [$];
    logic        m_ovf, m_perr;
    logic [15:0] e_rd, e_waddr, e_wdata;
    logic        e_wr_s;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0;
        m_q.delete();
        m_ovf = 1'b0; m_perr = 1'b0;
        e_rd = 16'h0; e_wr_s = 1'b0; e_waddr = 16'h0; e_wdata = 16'h0;
    endtask

    task automatic model_edge(input logic wr, input logic rd, input logic [15:0] a,
                              input logic [15:0] d, input logic rdy);
        logic [15:0] stat;
        logic [31:0] h;
        stat = {m_ovf, m_perr, 6'b0, 8'(m_q.size())};
        e_wr_s = 1'b0;
        if (rdy && m_q.size() > 0) begin
            h = m_q.pop_front();
            e_wr_s = 1'b1; e_waddr = h[31:16]; e_wdata = h[15:0];
        end
        if (wr && rd) begin
            m_perr = 1'b1;
        end else if (wr) begin
            if (int'(a) < NUM_REGS) m_regs[a] = d;
            else if (a == STAT_ADDR) begin
                if (d[15]) m_ovf = 1'b0;
                if (d[14]) m_perr = 1'b0;
            end else if (a >= WA_BASE) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back({a, d});
                else m_ovf = 1'b1;
            end
        end else if (rd) begin
            if (int'(a) < NUM_REGS) e_rd = m_regs[a];
            else if (a == STAT_ADDR) e_rd = stat;
            else e_rd = 16'h0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rd"},    32'(xa_data_rd), 32'(e_rd));
        chk({tag, ".wr_s"},  32'(wa_wr_s),    32'(e_wr_s));
        chk({tag, ".waddr"}, 32'(wa_addr),    32'(e_waddr));
        chk({tag, ".wdata"}, 32'(wa_data_wr), 32'(e_wdata));
    endtask

    task automatic step(input string tag, input logic wr, input logic rd, input logic [15:0] a,
                        input logic [15:0] d, input logic rdy);
        xa_wr_s = wr; xa_rd_s = rd; xa_addr = a; xa_data_wr = d; wa_rdy = rdy;
        @(posedge clk);
        model_edge(wr, rd, a, d, rdy);
        #1;
        chk_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rdat;
        logic rw, rr, ry;
        int k;

        rst_n = 1'b0; xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_addr = 16'h0; xa_data_wr = 16'h0; wa_rdy = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_model("reset");

        // Reads after reset
        step("rd_reg3", 1'b0, 1'b1, 16'd3, 16'h0, 1'b1);
        chk("rd_reg3_const", 32'(xa_data_rd), 32'h0);
        step("rd_stat0", 1'b0, 1'b1, STAT_ADDR, 16'h0, 1'b1);
        chk("rd_stat0_const", 32'(xa_data_rd), 32'h0);
        chk("rd_stat0_wr_s", 32'(wa_wr_s), 32'h0);

        // Local write then read back
        step("wr_reg5", 1'b1, 1'b0, 16'd5, 16'hA5A5, 1'b1);
        step("rd_reg5", 1'b0, 1'b1, 16'd5, 16'h0, 1'b1);
        chk("rd_reg5_const", 32'(xa_data_rd), 32'hA5A5);

        // Forward latency: pulse visible after second edge only
        step("fwd_push", 1'b1, 1'b0, 16'h1004, 16'h1234, 1'b1);
        chk("fwd_lat1", 32'(wa_wr_s), 32'h0);
        step("fwd_pop", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        chk("fwd_lat2", 32'({wa_wr_s, wa_addr, wa_data_wr}), {15'h0, 1'b1, 16'h1004, 16'h1234});
        step("fwd_done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        chk("fwd_once", 32'(wa_wr_s), 32'h0);

        // Overflow: six pushes into a depth-4 FIFO with W side stalled
        for (int i = 0; i < 6; i++) step("ovf_push", 1'b1, 1'b0, WA_BASE + 16'(i), 16'(i), 1'b0);
        step("ovf_stat", 1'b0, 1'b1, STAT_ADDR, 16'h0, 1'b0);
        chk("ovf_stat_const", 32'(xa_data_rd), 32'h8004);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
            chk("drain_const", 32'({wa_wr_s, wa_data_wr}), 32'({1'b1, 16'(i)}));
        end
        step("drain_end", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step("ovf_clr", 1'b1, 1'b0, STAT_ADDR, 16'h8000, 1'b1);
        step("ovf_clr_rd", 1'b0, 1'b1, STAT_ADDR, 16'h0, 1'b1);
        chk("ovf_clr_const", 32'(xa_data_rd), 32'h0);

        // Protocol error: both strobes
        step("wr_reg2", 1'b1, 1'b0, 16'd2, 16'h2222, 1'b1);
        step("rd_reg2", 1'b0, 1'b1, 16'd2, 16'h0, 1'b1);
        step("perr", 1'b1, 1'b1, 16'd2, 16'hDEAD, 1'b1);
        chk("perr_hold", 32'(xa_data_rd), 32'h2222);
        step("perr_rd2", 1'b0, 1'b1, 16'd2, 16'h0, 1'b1);
        chk("perr_reg2", 32'(xa_data_rd), 32'h2222);
        step("perr_stat", 1'b0, 1'b1, STAT_ADDR, 16'h0, 1'b1);
        chk("perr_stat_const", 32'(xa_data_rd), 32'h4000);
        step("perr_clr", 1'b1, 1'b0, STAT_ADDR, 16'h4000, 1'b1);

        // Mid-operation reset with queued entries
        for (int i = 0; i < 3; i++) step("rst_q", 1'b1, 1'b0, 16'h2000 + 16'(i), 16'hBEE0 + 16'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async", 32'({wa_wr_s, wa_addr, wa_data_wr}), 32'h0);
        chk("rst_async_rd", 32'(xa_data_rd), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_idle1", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step("rst_idle2", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        chk("rst_no_wr", 32'(wa_wr_s), 32'h0);
        step("rst_stat", 1'b0, 1'b1, STAT_ADDR, 16'h0, 1'b1);
        chk("rst_stat_const", 32'(xa_data_rd), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 2)      ra = 16'($urandom_range(0, NUM_REGS - 1));
            else if (k == 3) ra = STAT_ADDR;
            else if (k <= 7) ra = 16'($urandom_range(int'(WA_BASE), 16'hFFFF));
            else begin
                ra = 16'($urandom_range(NUM_REGS, int'(WA_BASE) - 1));
                if (ra == STAT_ADDR) ra = STAT_ADDR - 16'd1;
            end
            rdat = 16'($urandom);
            k = $urandom_range(0, 19);
            rw = (k <= 8) || (k == 16);
            rr = (k >= 9 && k <= 16);
            ry = ($urandom_range(0, 2) != 0);
            step("rand", rw, rr, ra, rdat, ry);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
